// File: rtl/shift_unit_arbiter.sv
// Two-requester front end for a single shared 32-bit shifter (SLL/SRL/SRA/pass).
// Round-robin arbitration feeds a one-entry registered result buffer with per-requester completion counters.
module shift_unit_arbiter #(
    parameter int N = 32
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [N-1:0]         req0_in,
    input  logic [$clog2(N)-1:0] req0_shamt,
    input  logic [1:0]           req0_op,

    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [N-1:0]         req1_in,
    input  logic [$clog2(N)-1:0] req1_shamt,
    input  logic [1:0]           req1_op,

    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [N-1:0]         resp_data,
    output logic                 resp_id,

    output logic [15:0]          ops_done0,
    output logic [15:0]          ops_done1
);

    localparam int SW = $clog2(N);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;
    localparam logic [1:0] OP_PASS = 2'b11;

    logic [0:0]   state_q, state_d;
    logic [N-1:0] resp_data_q, resp_data_d;
    logic         resp_id_q, resp_id_d;
    logic         last_grant_q, last_grant_d;
    logic [15:0]  ops_done0_q, ops_done0_d;
    logic [15:0]  ops_done1_q, ops_done1_d;

    logic         grant0, grant1;
    logic         can_accept;
    logic         accept;
    logic         take;

    logic [N-1:0] sel_in;
    logic [SW-1:0] sel_shamt;
    logic [1:0]   sel_op;
    logic [N-1:0] shift_out;

    // Tie goes to whichever requester did not win the previous accept.
    always_comb begin
        grant0     = req0_valid & (~req1_valid | last_grant_q);
        grant1     = req1_valid & (~req0_valid | ~last_grant_q);
        can_accept = (state_q == ST_EMPTY) | resp_ready;
        req0_ready = ~rst & can_accept & grant0;
        req1_ready = ~rst & can_accept & grant1;
        accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);
        take       = (state_q == ST_FULL) & resp_ready;
    end

    // Operand mux ahead of the shifter so only one shifter is built.
    always_comb begin
        sel_in    = grant1 ? req1_in    : req0_in;
        sel_shamt = grant1 ? req1_shamt : req0_shamt;
        sel_op    = grant1 ? req1_op    : req0_op;
    end

    always_comb begin
        unique case (sel_op)
            OP_SLL:  shift_out = sel_in << sel_shamt;
            OP_SRL:  shift_out = sel_in >> sel_shamt;
            OP_SRA:  shift_out = N'($signed(sel_in) >>> sel_shamt);
            OP_PASS: shift_out = sel_in;
            default: shift_out = sel_in;
        endcase
    end

    // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d      = state_q;
        resp_data_d  = resp_data_q;
        resp_id_d    = resp_id_q;
        last_grant_d = last_grant_q;
        ops_done0_d  = ops_done0_q;
        ops_done1_d  = ops_done1_q;

        if (take) begin
            state_d = ST_EMPTY;
            if (resp_id_q) ops_done1_d = ops_done1_q + 16'd1;
            else           ops_done0_d = ops_done0_q + 16'd1;
        end

        if (accept) begin
            state_d      = ST_FULL;
            resp_data_d  = shift_out;
            resp_id_d    = grant1;
            last_grant_d = grant1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_EMPTY;
            resp_data_q  <= '0;
            resp_id_q    <= 1'b0;
            last_grant_q <= 1'b1;
            ops_done0_q  <= '0;
            ops_done1_q  <= '0;
        end else begin
            state_q      <= state_d;
            resp_data_q  <= resp_data_d;
            resp_id_q    <= resp_id_d;
            last_grant_q <= last_grant_d;
            ops_done0_q  <= ops_done0_d;
            ops_done1_q  <= ops_done1_d;
        end
    end

    assign resp_valid = (state_q == ST_FULL);
    assign resp_data  = resp_data_q;
    assign resp_id    = resp_id_q;
    assign ops_done0  = ops_done0_q;
    assign ops_done1  = ops_done1_q;

endmodule

// File: tb/tb_shift_unit_arbiter.sv
// Scoreboard bench for shift_unit_arbiter: a reference model predicts grants and results,
// expected responses are queued on accept and compared when taken.
module tb_shift_unit_arbiter;

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;
    localparam logic [1:0] OP_PASS = 2'b11;

    typedef struct packed {
        logic        id;
        logic [31:0] data;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_in, req1_in;
    logic [4:0]  req0_shamt, req1_shamt;
    logic [1:0]  req0_op, req1_op;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_data;
    logic        resp_id;
    logic [15:0] ops_done0, ops_done1;

    int vectors = 0;
    int miscompares = 0;

    resp_t       sb[$];
    logic        m_full;
    logic        m_last;
    logic [15:0] m_cnt0, m_cnt1;

    localparam logic [31:0] BND_IN  [10] = '{32'hA5C3_0F96, 32'hA5C3_0F96, 32'hA5C3_0F96, 32'hA5C3_0F96,
                                             32'h0000_0001, 32'h8000_0000, 32'h8000_0000, 32'h1234_5678,
                                             32'h7FFF_FFFF, 32'hF000_0001};
    localparam logic [4:0]  BND_SH  [10] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd31, 5'd31, 5'd31, 5'd17, 5'd31, 5'd4};
    localparam logic [1:0]  BND_OP  [10] = '{OP_SLL, OP_SRL, OP_SRA, OP_PASS, OP_SLL, OP_SRL, OP_SRA,
                                             OP_PASS, OP_SRA, OP_SRA};
    localparam logic [31:0] BND_EXP [10] = '{32'hA5C3_0F96, 32'hA5C3_0F96, 32'hA5C3_0F96, 32'hA5C3_0F96,
                                             32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h1234_5678,
                                             32'h0000_0000, 32'hFF00_0000};

    shift_unit_arbiter #(.N(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_in    (req0_in),
        .req0_shamt (req0_shamt),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_in    (req1_in),
        .req1_shamt (req1_shamt),
        .req1_op    (req1_op),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id),
        .ops_done0  (ops_done0),
        .ops_done1  (ops_done1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Bit-level reference shifter, written independently of any shift operator.
    function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [4:0] sh, input logic [1:0] op);
        logic [31:0] r;
        int s;
        s = int'(sh);
        for (int i = 0; i < 32; i++) begin
            case (op)
                OP_SLL:  r[i] = (i >= s) ? a[i - s] : 1'b0;
                OP_SRL:  r[i] = (i + s <= 31) ? a[i + s] : 1'b0;
                OP_SRA:  r[i] = (i + s <= 31) ? a[i + s] : a[31];
                default: r[i] = a[i];
            endcase
        end
        return r;
    endfunction

    task automatic model_reset();
        m_full = 1'b0;
        m_last = 1'b1;
        m_cnt0 = '0;
        m_cnt1 = '0;
        sb.delete();
    endtask

    // One cycle: drive at negedge, check settled outputs, update model, wait for the rising edge.
    task automatic step(input logic v0, input logic [31:0] a0, input logic [4:0] s0, input logic [1:0] o0,
                        input logic v1, input logic [31:0] a1, input logic [4:0] s1, input logic [1:0] o1,
                        input logic rr);
        logic  e_can, e_r0, e_r1;
        resp_t e;
        @(negedge clk);
        req0_valid = v0; req0_in = a0; req0_shamt = s0; req0_op = o0;
        req1_valid = v1; req1_in = a1; req1_shamt = s1; req1_op = o1;
        resp_ready = rr;
        #1;
        check("ops_done0", ops_done0, m_cnt0);
        check("ops_done1", ops_done1, m_cnt1);
        check("resp_valid", resp_valid, m_full);
        if (m_full && sb.size() > 0) begin
            check("resp_data", resp_data, sb[0].data);
            check("resp_id", resp_id, sb[0].id);
        end
        e_can = !m_full || rr;
        e_r0  = e_can && v0 && (!v1 || m_last);
        e_r1  = e_can && v1 && (!v0 || !m_last);
        check("req0_ready", req0_ready, e_r0);
        check("req1_ready", req1_ready, e_r1);
        if (m_full && rr && sb.size() > 0) begin
            e = sb.pop_front();
            if (e.id) m_cnt1 = m_cnt1 + 16'd1;
            else      m_cnt0 = m_cnt0 + 16'd1;
            m_full = 1'b0;
        end
        if (e_r0) begin
            sb.push_back('{id: 1'b0, data: ref_shift(a0, s0, o0)});
            m_last = 1'b0;
            m_full = 1'b1;
        end else if (e_r1) begin
            sb.push_back('{id: 1'b1, data: ref_shift(a1, s1, o1)});
            m_last = 1'b1;
            m_full = 1'b1;
        end
        @(posedge clk);
    endtask

    task automatic idle(input logic rr);
        step(1'b0, 32'h0, 5'd0, OP_SLL, 1'b0, 32'h0, 5'd0, OP_SLL, rr);
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b1; req0_in = 32'hDEAD_BEEF; req0_shamt = 5'd3; req0_op = OP_SLL;
        req1_valid = 1'b1; req1_in = 32'hCAFE_F00D; req1_shamt = 5'd5; req1_op = OP_SRL;
        resp_ready = 1'b1;
        model_reset();
        #12;
        check("rst resp_valid", resp_valid, 1'b0);
        check("rst resp_data", resp_data, 32'h0);
        check("rst resp_id", resp_id, 1'b0);
        check("rst req0_ready", req0_ready, 1'b0);
        check("rst req1_ready", req1_ready, 1'b0);
        check("rst ops_done0", ops_done0, 16'h0);
        check("rst ops_done1", ops_done1, 16'h0);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst = 1'b0;

        // Tie fairness: first tie after reset goes to requester 0, then alternates.
        for (int k = 0; k < 4; k++)
            step(1'b1, 32'h0000_0100 + k, 5'(k), OP_SLL, 1'b1, 32'h8000_0000 + k, 5'(k + 1), OP_SRA, 1'b1);
        idle(1'b1);
        idle(1'b1);
        check("tie ops_done0", ops_done0, 16'd2);
        check("tie ops_done1", ops_done1, 16'd2);

        // Single SRA op; drain keeps the last data and id on the outputs.
        step(1'b1, 32'hF000_0001, 5'd4, OP_SRA, 1'b0, 32'h0, 5'd0, OP_SLL, 1'b1);
        #1;
        check("single resp_valid", resp_valid, 1'b1);
        check("single resp_data", resp_data, 32'hFF00_0000);
        check("single resp_id", resp_id, 1'b0);
        idle(1'b1);
        idle(1'b1);
        check("single held data", resp_data, 32'hFF00_0000);
        check("single ops_done0", ops_done0, 16'd3);

        // Backpressure: hold FULL for three cycles, then drain and refill in one edge.
        step(1'b1, 32'h0F0F_0F0F, 5'd8, OP_SLL, 1'b0, 32'h0, 5'd0, OP_SLL, 1'b0);
        for (int k = 0; k < 3; k++)
            step(1'b1, 32'h1111_0000 + k, 5'd1, OP_SRL, 1'b1, 32'h2222_0000 + k, 5'd2, OP_SLL, 1'b0);
        step(1'b1, 32'h1357_9BDF, 5'd1, OP_SRL, 1'b1, 32'h2468_ACE0, 5'd2, OP_SLL, 1'b1);
        #1;
        check("bp refill resp_valid", resp_valid, 1'b1);
        check("bp refill resp_id", resp_id, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Boundary table through requester 1 at full throughput.
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 32'h0, 5'd0, OP_SLL, 1'b1, BND_IN[k], BND_SH[k], BND_OP[k], 1'b1);
            #1;
            check($sformatf("bnd%0d", k), resp_data, BND_EXP[k]);
        end
        idle(1'b1);

        // Random mixed traffic with occasional backpressure.
        for (int k = 0; k < 200; k++)
            step(1'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 3) != 0));
        idle(1'b1);
        idle(1'b1);

        // Reset while FULL discards the buffered result and clears counters.
        step(1'b1, 32'hABCD_1234, 5'd7, OP_SRL, 1'b0, 32'h0, 5'd0, OP_SLL, 1'b0);
        @(negedge clk);
        req0_valid = 1'b1; req1_valid = 1'b1; resp_ready = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("midrst resp_valid", resp_valid, 1'b0);
        check("midrst ops_done0", ops_done0, 16'h0);
        check("midrst ops_done1", ops_done1, 16'h0);
        check("midrst req0_ready", req0_ready, 1'b0);
        check("midrst req1_ready", req1_ready, 1'b0);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst = 1'b0;
        model_reset();
        step(1'b1, 32'h0000_00F0, 5'd4, OP_SRL, 1'b1, 32'h0000_0F00, 5'd4, OP_SLL, 1'b1);
        #1;
        check("post-rst tie id", resp_id, 1'b0);
        idle(1'b1);

        // Counter wrap: 65536 takes for requester 1.
        for (int k = 0; k < 65536; k++)
            step(1'b0, 32'h0, 5'd0, OP_SLL, 1'b1, $urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), 1'b1);
        idle(1'b1);
        idle(1'b1);
        check("wrap ops_done1", ops_done1, 16'h0000);
        check("wrap ops_done0", ops_done0, 16'h0001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/shift_unit_arbiter.md
# shift_unit_arbiter

Shares one 32-bit shift datapath (SLL, SRL, SRA) between two requesters with a round-robin arbiter and a one-entry registered result buffer. Each requester presents an operand, shift amount and opcode on a valid/ready channel. Results return on a single shared response channel tagged with the requester ID. The block sits between the two issuing units (ALU port and address-generation port) and the shifter, so only one shifter instance is built.

## Interface
- N, 32, datapath width; only 32 is supported.
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle when high with req0_valid.
- req0_in  input  N  operand.
- req0_shamt  input  $clog2(N)  shift amount 0..31.
- req0_op  input  2  00 SLL, 01 SRL, 10 SRA, 11 pass-through.
- req1_valid, req1_ready, req1_in, req1_shamt, req1_op: same as requester 0.
- resp_valid  output  1  resp_data/resp_id hold a completed result.
- resp_ready  input  1  consumer takes the result when high with resp_valid.
- resp_data  output  N  shift result.
- resp_id  output  1  requester that issued the result (0 or 1).
- ops_done0, ops_done1  output  16  completed-operation counters per requester.

## Operation
- States: EMPTY (resp_valid=0), FULL (resp_valid=1); the buffer is one entry.
- can_accept = EMPTY, or FULL with resp_ready=1 (drain and refill in the same cycle).
- Round-robin register last_grant (1 bit):
  - If only one requester is valid, it wins.
  - If both are valid, the one not equal to last_grant wins.
- reqX_ready = can_accept & (requester X wins). The loser's ready is 0.
  - reqX_ready may depend combinationally on req0_valid/req1_valid and resp_ready.
  - Requesters must not make valid depend on ready.
- On accept (reqX_valid & reqX_ready):
  - resp_data <= the winner's shift result.
  - resp_id <= X.
  - resp_valid <= 1.
  - last_grant <= X.
- Shift results:
  - SLL: in << shamt.
  - SRL: zero-filled right shift.
  - SRA: right shift filled with in[31]; shamt=31 gives all copies of bit 31.
  - Op 11: result = in unchanged.
- Drain without accept (FULL, resp_ready=1, no winner): resp_valid <= 0. resp_data and resp_id keep their last values.
- FULL with resp_ready=0: resp_data, resp_id and resp_valid hold stable; both readies are 0.
- ops_doneX increments by 1 each cycle a response with resp_id=X is taken (resp_valid & resp_ready). It wraps 0xFFFF -> 0x0000.
- Requester inputs are sampled only on the accept edge. Changes while not accepted have no effect.

## Timing
- Reset values, applied immediately on rst assertion and held while rst=1:
  - resp_valid=0, resp_data=0, resp_id=0.
  - last_grant=1, so requester 0 wins the first tie.
  - ops_done0=0, ops_done1=0.
  - req0_ready=0, req1_ready=0.
- Latency: a request accepted at edge T shows resp_valid=1 with its result after edge T, i.e. 1 cycle.
- Throughput: one operation per cycle while resp_ready=1 is held.
- Simultaneous drain and accept in one cycle: the counter for the old resp_id increments and the new entry loads at the same edge. resp_valid stays 1.
- Reset mid-operation: an in-flight buffered result is discarded. No counter increments for it.
- Back-to-back ties alternate grants: 0, 1, 0, 1, ...

## Test plan
- Single op: req0 in=0xF000_0001, shamt=4, op=SRA, resp_ready=1 -> next cycle resp_valid=1, resp_data=0xFF00_0000, resp_id=0, ops_done0=1 after the take.
- Tie fairness: both requesters valid for 4 cycles, resp_ready=1 -> resp_id sequence 0,1,0,1 and each counter ends at 2.
- Backpressure: buffer FULL, resp_ready=0 for 3 cycles while both are valid -> both readies 0, resp_data stable. Raising resp_ready gives a same-cycle drain plus accept.
- Boundaries:
  - shamt=0 on all ops returns in unchanged.
  - shamt=31: SLL 0x0000_0001 -> 0x8000_0000; SRL 0x8000_0000 -> 0x0000_0001; SRA 0x8000_0000 -> 0xFFFF_FFFF.
  - op=11 returns in.
- Reset mid-operation: assert rst while FULL -> resp_valid drops immediately, counters are 0. The first tie after release grants requester 0.
- Counter wrap: take 65536 responses for requester 1 -> ops_done1 wraps to 0x0000, ops_done0 unchanged.
